// File: rtl/fft_butterfly_r2_pipe.sv
// Radix-2 complex butterfly (DIT/DIF) with twiddle multiplier,
// 1/2 scaling, rounding, saturation and a stall-all valid/ready pipeline.
//
// Ports:
//   clk, rst_n                        clock, sync active-low reset
//   in_valid/in_ready                 input handshake (A, B, W, flags)
//   in_a_re/im, in_b_re/im            operands A, B (DATA_W signed)
//   tw_re/im, tw_bypass               twiddle Q1.(TW_W-1); bypass = W of +1
//   scale_en                          halve results with rounding
//   out_valid/out_ready               output handshake
//   out_x_re/im, out_y_re/im          sum / difference results
//   out_sat, ovf_sticky, ovf_clr      saturation flag, sticky flag, clear
module fft_butterfly_r2_pipe #(
  parameter int DATA_W     = 16,
  parameter int TW_W       = 16,
  parameter int MUL_STAGES = 2,
  parameter int DIF        = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [DATA_W-1:0] in_b_re,
  input  logic signed [DATA_W-1:0] in_b_im,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  input  logic                     tw_bypass,
  input  logic                     scale_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x_re,
  output logic signed [DATA_W-1:0] out_x_im,
  output logic signed [DATA_W-1:0] out_y_re,
  output logic signed [DATA_W-1:0] out_y_im,
  output logic                     out_sat,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int L  = MUL_STAGES + 2;
  localparam int MW = (DIF != 0) ? DATA_W + 1 : DATA_W;
  localparam int PW = MW + TW_W + 1;
  localparam int RW = MW + 1;
  localparam int SW = DATA_W + 2;

  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (TW_W - 2);
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Returns {saturated, value}.
  function automatic logic [DATA_W:0] scsat(
    input logic signed [SW-1:0] v,
    input logic                 sc
  );
    logic signed [SW:0] t;
    t = (SW+1)'(v);
    if (sc) t = (t + (SW+1)'(1)) >>> 1;
    if (t > (SW+1)'(DMAX)) return {1'b1, DMAX};
    if (t < (SW+1)'(DMIN)) return {1'b1, DMIN};
    return {1'b0, DATA_W'(t)};
  endfunction

  logic              adv;
  logic [L-1:0]      vld_q;
  logic [L-2:0]      sc_q;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else if (adv) vld_q <= {vld_q[L-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (adv) sc_q <= {sc_q[L-3:0], scale_en};
  end

  // Complex multiplier; operand source depends on DIT/DIF.
  logic signed [MW-1:0]   op_re, op_im;
  logic signed [TW_W-1:0] w_re, w_im;
  logic                   byp;
  logic signed [PW-1:0]   pre_re, pre_im;
  logic signed [PW-1:0]   mre_q [MUL_STAGES];
  logic signed [PW-1:0]   mim_q [MUL_STAGES];
  logic signed [RW-1:0]   rnd_re, rnd_im;

  always_comb begin
    logic signed [PW-1:0] ore, oim, wre, wim;
    ore = PW'(op_re);
    oim = PW'(op_im);
    wre = PW'(w_re);
    wim = PW'(w_im);
    // Bypass pre-shifts so the common rounding step is exact.
    if (byp) begin
      pre_re = ore <<< (TW_W - 1);
      pre_im = oim <<< (TW_W - 1);
    end else begin
      pre_re = ore * wre - oim * wim;
      pre_im = ore * wim + oim * wre;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mre_q[0] <= pre_re;
      mim_q[0] <= pre_im;
      for (int k = 1; k < MUL_STAGES; k++) begin
        mre_q[k] <= mre_q[k-1];
        mim_q[k] <= mim_q[k-1];
      end
    end
  end

  assign rnd_re = RW'((mre_q[MUL_STAGES-1] + HALF) >>> (TW_W - 1));
  assign rnd_im = RW'((mim_q[MUL_STAGES-1] + HALF) >>> (TW_W - 1));

  logic signed [SW-1:0] fx_re, fx_im, fy_re, fy_im;

  if (DIF == 0) begin : g_dit
    logic signed [DATA_W-1:0] a_re_q [MUL_STAGES];
    logic signed [DATA_W-1:0] a_im_q [MUL_STAGES];
    logic signed [SW-1:0]     x_re_q, x_im_q, y_re_q, y_im_q;

    assign op_re = in_b_re;
    assign op_im = in_b_im;
    assign w_re  = tw_re;
    assign w_im  = tw_im;
    assign byp   = tw_bypass;

    always_ff @(posedge clk) begin
      if (adv) begin
        a_re_q[0] <= in_a_re;
        a_im_q[0] <= in_a_im;
        for (int k = 1; k < MUL_STAGES; k++) begin
          a_re_q[k] <= a_re_q[k-1];
          a_im_q[k] <= a_im_q[k-1];
        end
        x_re_q <= SW'(a_re_q[MUL_STAGES-1]) + SW'(rnd_re);
        x_im_q <= SW'(a_im_q[MUL_STAGES-1]) + SW'(rnd_im);
        y_re_q <= SW'(a_re_q[MUL_STAGES-1]) - SW'(rnd_re);
        y_im_q <= SW'(a_im_q[MUL_STAGES-1]) - SW'(rnd_im);
      end
    end

    assign fx_re = x_re_q;
    assign fx_im = x_im_q;
    assign fy_re = y_re_q;
    assign fy_im = y_im_q;
  end else begin : g_dif
    logic signed [DATA_W:0]   s_re_q, s_im_q, d_re_q, d_im_q;
    logic signed [TW_W-1:0]   w_re_q, w_im_q;
    logic                     byp_q;
    logic signed [DATA_W:0]   sd_re_q [MUL_STAGES];
    logic signed [DATA_W:0]   sd_im_q [MUL_STAGES];

    always_ff @(posedge clk) begin
      if (adv) begin
        s_re_q <= (DATA_W+1)'(in_a_re) + (DATA_W+1)'(in_b_re);
        s_im_q <= (DATA_W+1)'(in_a_im) + (DATA_W+1)'(in_b_im);
        d_re_q <= (DATA_W+1)'(in_a_re) - (DATA_W+1)'(in_b_re);
        d_im_q <= (DATA_W+1)'(in_a_im) - (DATA_W+1)'(in_b_im);
        w_re_q <= tw_re;
        w_im_q <= tw_im;
        byp_q  <= tw_bypass;
        sd_re_q[0] <= s_re_q;
        sd_im_q[0] <= s_im_q;
        for (int k = 1; k < MUL_STAGES; k++) begin
          sd_re_q[k] <= sd_re_q[k-1];
          sd_im_q[k] <= sd_im_q[k-1];
        end
      end
    end

    assign op_re = d_re_q;
    assign op_im = d_im_q;
    assign w_re  = w_re_q;
    assign w_im  = w_im_q;
    assign byp   = byp_q;

    assign fx_re = SW'(sd_re_q[MUL_STAGES-1]);
    assign fx_im = SW'(sd_im_q[MUL_STAGES-1]);
    assign fy_re = SW'(rnd_re);
    assign fy_im = SW'(rnd_im);
  end

  // Output stage: scale, saturate, register.
  logic [DATA_W:0] rx_re, rx_im, ry_re, ry_im;

  assign rx_re = scsat(fx_re, sc_q[L-2]);
  assign rx_im = scsat(fx_im, sc_q[L-2]);
  assign ry_re = scsat(fy_re, sc_q[L-2]);
  assign ry_im = scsat(fy_im, sc_q[L-2]);

  logic signed [DATA_W-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
  logic                     sat_q, ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_re_q <= '0;
      x_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
      sat_q  <= 1'b0;
    end else if (adv) begin
      x_re_q <= rx_re[DATA_W-1:0];
      x_im_q <= rx_im[DATA_W-1:0];
      y_re_q <= ry_re[DATA_W-1:0];
      y_im_q <= ry_im[DATA_W-1:0];
      sat_q  <= vld_q[L-2] &
                (rx_re[DATA_W] | rx_im[DATA_W] |
                 ry_re[DATA_W] | ry_im[DATA_W]);
    end
  end

  // A held pair counts only on the cycle it leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= (ovf_q & ~ovf_clr) | (out_valid & sat_q & adv);
  end

  assign out_valid  = vld_q[L-1];
  assign out_x_re   = x_re_q;
  assign out_x_im   = x_im_q;
  assign out_y_re   = y_re_q;
  assign out_y_im   = y_im_q;
  assign out_sat    = sat_q;
  assign ovf_sticky = ovf_q;

endmodule
